addr_demux_deser: RTL and testbench
===================================

ADDR_DEMUX_DESER -- requirements
Module: addr_demux_deser

Interface
REQ-001 The block SHALL have parameter RESET_Q, default 8'h00, the value loaded into Q at reset.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port G_n, input, 1, an active-low enable; when high, nothing is written or counted.
REQ-005 The block SHALL have port mode, input, 1: 0 = addressed write, 1 = sequential frame capture.
REQ-006 The block SHALL have port sel, input, 3, the target bit index in addressed mode, ignored in sequential mode.
REQ-007 The block SHALL have port D, input, 1, the serial data bit.
REQ-008 The block SHALL have port Q, output, 8, the parallel output register.
REQ-009 The block SHALL have port cnt, output, 3, the current sequential bit index.
REQ-010 The block SHALL have port busy, output, 1, high while a sequential frame is partially received.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when a frame has been committed to Q.
REQ-012 The block SHALL have port perr, output, 1, the parity error flag, valid alongside done.

Function
REQ-013 In addressed mode (mode=0) with G_n=0, Q[sel] SHALL take D on the next rising edge; all other Q bits SHALL hold (latency 1).
REQ-014 The FSM SHALL have states IDLE and RECV.
REQ-015 With mode=1 and G_n=0 in IDLE: D SHALL be written to shadow[0], cnt SHALL become 1, and the FSM SHALL enter RECV.
REQ-016 In RECV with G_n=0: shadow[cnt] SHALL take D and cnt SHALL increment each cycle.
REQ-017 On the final data bit (cnt=7, no parity build), Q SHALL take {D, shadow[6:0]} and done SHALL pulse for one cycle.
REQ-018 On frame commit, cnt SHALL wrap to 0 and the FSM SHALL return to IDLE; a new frame MAY start on the next cycle.
REQ-019 Q SHALL NOT change during sequential capture until the frame commits.
REQ-020 If G_n=1 in RECV, the FSM SHALL pause: cnt and shadow hold, and busy stays high.
REQ-021 If mode changes to 0 in RECV, the frame SHALL be aborted: cnt=0, IDLE, no done; the addressed write in that cycle SHALL still occur.
REQ-022 busy SHALL equal (state==RECV).
REQ-023 done SHALL be registered and low in all cycles other than the commit cycle.

Reset
REQ-024 rst_n low SHALL immediately set Q=RESET_Q, shadow=0, cnt=0, state=IDLE, done=0, perr=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame with no done pulse.

Configuration
REQ-026 With macro DEMUX_PARITY_EN defined, a frame SHALL be 9 bits: 8 data bits, then an even-parity bit captured at cnt=8, and cnt SHALL widen internally to 4 bits (the port stays 3 bits, saturating at 7).
REQ-027 With DEMUX_PARITY_EN defined, commit SHALL occur on the parity bit, and perr SHALL be set to (^data) ^ D and held until the next commit or reset.
REQ-028 Without DEMUX_PARITY_EN, the frame SHALL be 8 bits and perr SHALL be tied to 0.

Structure
REQ-029 Package demux_pkg SHALL hold the state enum (IDLE, RECV), DATA_W=8, and FRAME_LEN (8 or 9, selected by the macro).
REQ-030 The index counter SHALL be a sub-module, frame_counter, providing clear, enable and wrap flag.

Verification
REQ-031 Addressed mode: mode=0, G_n=0, sel=5, D=1 from reset -> Q=8'h20 after one clock; with G_n=1 instead -> Q holds 8'h00.
REQ-032 Sequential mode: D stream 1,0,1,1,0,0,1,0 (bit0 first) with G_n=0 -> Q=8'h4D on the 8th edge, done high exactly one cycle, Q unchanged during bits 0-6.
REQ-033 Pause: same stream with G_n=1 for 3 cycles after bit 3 -> cnt holds at 4, busy stays 1, final Q=8'h4D.
REQ-034 Abort: mode switches to 0 after 5 bits with sel=0, D=1 -> no done, cnt=0, Q[0]=1 and the rest of Q unchanged.
REQ-035 Reset mid-frame after 4 bits -> Q=RESET_Q and cnt=0 immediately, with no done pulse.
REQ-036 With DEMUX_PARITY_EN: data 8'h4D followed by parity bit 0 -> done, perr=0; followed by parity bit 1 -> perr=1.

Source files
------------

// File: rtl/addr_demux_deser_pkg.sv
// Shared types and frame geometry for the addressed demux / serial deserializer.
// Frame length follows the DEMUX_PARITY_EN macro (9 bits with parity, 8 without).
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

`ifdef DEMUX_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  localparam int CNT_W = $clog2(FRAME_LEN);

endpackage

// File: rtl/addr_demux_deser_if.sv
// Bus bundle for addr_demux_deser: serial control/data in, parallel result and status out.
interface addr_demux_deser_if;
  import demux_pkg::*;

  logic                    G_n;
  logic                    mode;
  logic [IDX_W-1:0]        sel;
  logic                    D;
  logic [DATA_W-1:0]       Q;
  logic [IDX_W-1:0]        cnt;
  logic                    busy;
  logic                    done;
  logic                    perr;

  modport master (
    output G_n, mode, sel, D,
    input  Q, cnt, busy, done, perr
  );

  modport slave (
    input  G_n, mode, sel, D,
    output Q, cnt, busy, done, perr
  );

endinterface

// File: rtl/addr_demux_deser_frame_counter.sv
// Bit-index counter for sequential capture: synchronous clear, count enable,
// and a wrap flag that is high while the index sits on the last bit of a frame.
module frame_counter #(
  parameter int LEN = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(LEN - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/addr_demux_deser.sv
// Addressed 1-to-8 bit demux plus sequential 8-bit frame deserializer sharing one output register.
// Optional DEMUX_PARITY_EN adds a trailing even-parity bit per frame and drives perr.
module addr_demux_deser
  import demux_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_Q = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  addr_demux_deser_if.slave   bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              done_q, done_d;
  logic              cnt_clr, cnt_en, cnt_wrap;
  logic [CNT_W-1:0]  cnt_full;
  logic              data_bit;

  frame_counter #(
    .LEN (FRAME_LEN),
    .W   (CNT_W)
  ) u_frame_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt_full),
    .wrap  (cnt_wrap)
  );

`ifdef DEMUX_PARITY_EN
  logic perr_q, perr_d;

  // Index 8 is the parity slot; it is not a data bit and the port saturates at 7.
  assign data_bit = ~cnt_full[CNT_W-1];
  assign bus.cnt  = cnt_full[CNT_W-1] ? 3'd7 : cnt_full[IDX_W-1:0];
  assign bus.perr = perr_q;
`else
  assign data_bit = 1'b1;
  assign bus.cnt  = cnt_full;
  assign bus.perr = 1'b0;
`endif

  assign bus.Q    = q_q;
  assign bus.busy = (state_q == RECV);
  assign bus.done = done_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
`ifdef DEMUX_PARITY_EN
    perr_d   = perr_q;
`endif
    if (!bus.G_n) begin
      if (!bus.mode) begin
        // Addressed write always lands, even when it aborts a partial frame.
        q_d[bus.sel] = bus.D;
        if (state_q == RECV) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end else if (state_q == IDLE) begin
        shadow_d[0] = bus.D;
        cnt_en      = 1'b1;
        state_d     = RECV;
      end else begin
        cnt_en = 1'b1;
        if (data_bit) begin
          shadow_d[cnt_full[IDX_W-1:0]] = bus.D;
        end
        if (cnt_wrap) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef DEMUX_PARITY_EN
          q_d    = shadow_q;
          perr_d = (^shadow_q) ^ bus.D;
`else
          q_d    = shadow_d;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      q_q      <= RESET_Q;
      done_q   <= 1'b0;
`ifdef DEMUX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      done_q   <= done_d;
`ifdef DEMUX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_addr_demux_deser.sv
// Directed bench for addr_demux_deser: addressed writes, frame capture, pause, abort, reset.
// Sequential checks follow the build: 8-bit frames by default, 9-bit with DEMUX_PARITY_EN.
module tb_addr_demux_deser;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  addr_demux_deser_if bus ();

  addr_demux_deser #(
    .RESET_Q (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d);
    bus.mode = 1'b1;
    bus.G_n  = 1'b0;
    bus.D    = d;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fa;
    logic [7:0] fb;
    fa = 8'h4D;
    fb = 8'hB2;

    bus.G_n  = 1'b1;
    bus.mode = 1'b0;
    bus.sel  = 3'd0;
    bus.D    = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("rst_Q",    bus.Q,           8'h00);
    chk("rst_cnt",  {5'd0, bus.cnt}, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_done", {7'd0, bus.done}, 8'h00);
    chk("rst_perr", {7'd0, bus.perr}, 8'h00);
    tick();
    rst_n = 1'b1;

    // Addressed mode
    bus.sel = 3'd5; bus.D = 1'b1; bus.G_n = 1'b1;
    tick();
    chk("addr_gated_hold", bus.Q, 8'h00);
    bus.G_n = 1'b0;
    tick();
    chk("addr_sel5", bus.Q, 8'h20);
    chk("addr_busy", {7'd0, bus.busy}, 8'h00);
    bus.sel = 3'd2;
    tick();
    chk("addr_sel2", bus.Q, 8'h24);
    bus.sel = 3'd5; bus.D = 1'b0;
    tick();
    chk("addr_clr5", bus.Q, 8'h04);
    bus.sel = 3'd2;
    tick();
    chk("addr_clr2", bus.Q, 8'h00);
    chk("addr_done", {7'd0, bus.done}, 8'h00);

`ifdef DEMUX_PARITY_EN
    for (int i = 0; i < 8; i++) begin
      send_bit(fa[i]);
      chk("par_Q_hold", bus.Q, 8'h00);
      chk("par_done_lo", {7'd0, bus.done}, 8'h00);
    end
    chk("par_cnt_sat", {5'd0, bus.cnt}, 8'h07);
    chk("par_busy", {7'd0, bus.busy}, 8'h01);
    send_bit(1'b0);
    chk("par0_done", {7'd0, bus.done}, 8'h01);
    chk("par0_Q", bus.Q, 8'h4D);
    chk("par0_perr", {7'd0, bus.perr}, 8'h00);
    chk("par0_cnt", {5'd0, bus.cnt}, 8'h00);
    for (int i = 0; i < 8; i++) send_bit(fa[i]);
    send_bit(1'b1);
    chk("par1_done", {7'd0, bus.done}, 8'h01);
    chk("par1_perr", {7'd0, bus.perr}, 8'h01);
    bus.G_n = 1'b1;
    tick();
    chk("par1_perr_held", {7'd0, bus.perr}, 8'h01);
    chk("par1_done_lo", {7'd0, bus.done}, 8'h00);
`else
    // Sequential frame 0x4D then 0xB2 back to back
    for (int i = 0; i < 8; i++) begin
      send_bit(fa[i]);
      if (i < 7) begin
        chk("seq_Q_hold", bus.Q, 8'h00);
        chk("seq_cnt", {5'd0, bus.cnt}, 8'(i + 1));
        chk("seq_busy", {7'd0, bus.busy}, 8'h01);
        chk("seq_done_lo", {7'd0, bus.done}, 8'h00);
      end
    end
    chk("seq_Q", bus.Q, 8'h4D);
    chk("seq_done", {7'd0, bus.done}, 8'h01);
    chk("seq_cnt_wrap", {5'd0, bus.cnt}, 8'h00);
    chk("seq_idle", {7'd0, bus.busy}, 8'h00);
    chk("seq_perr", {7'd0, bus.perr}, 8'h00);
    send_bit(fb[0]);
    chk("b2b_done_lo", {7'd0, bus.done}, 8'h00);
    chk("b2b_cnt", {5'd0, bus.cnt}, 8'h01);
    chk("b2b_Q_hold", bus.Q, 8'h4D);
    for (int i = 1; i < 8; i++) send_bit(fb[i]);
    chk("b2b_Q", bus.Q, 8'hB2);
    chk("b2b_done", {7'd0, bus.done}, 8'h01);
    bus.G_n = 1'b1;
    tick();
    chk("b2b_done_once", {7'd0, bus.done}, 8'h00);
    chk("b2b_Q_stay", bus.Q, 8'hB2);

    // Pause for three gated cycles after bit 3
    rst_n = 1'b0;
    #1;
    chk("pause_rstQ", bus.Q, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(fa[i]);
    bus.G_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pause_cnt", {5'd0, bus.cnt}, 8'h04);
      chk("pause_busy", {7'd0, bus.busy}, 8'h01);
      chk("pause_done_lo", {7'd0, bus.done}, 8'h00);
    end
    for (int i = 4; i < 8; i++) send_bit(fa[i]);
    chk("pause_Q", bus.Q, 8'h4D);
    chk("pause_done", {7'd0, bus.done}, 8'h01);

    // Abort after 5 bits by switching to addressed mode
    bus.mode = 1'b0; bus.sel = 3'd0; bus.D = 1'b0; bus.G_n = 1'b0;
    tick();
    chk("abort_prep", bus.Q, 8'h4C);
    for (int i = 0; i < 5; i++) send_bit(fa[i]);
    chk("abort_cnt5", {5'd0, bus.cnt}, 8'h05);
    bus.mode = 1'b0; bus.sel = 3'd0; bus.D = 1'b1; bus.G_n = 1'b0;
    tick();
    chk("abort_done", {7'd0, bus.done}, 8'h00);
    chk("abort_cnt", {5'd0, bus.cnt}, 8'h00);
    chk("abort_busy", {7'd0, bus.busy}, 8'h00);
    chk("abort_Q", bus.Q, 8'h4D);
    bus.G_n = 1'b1;
    tick();
    chk("abort_no_done", {7'd0, bus.done}, 8'h00);
`endif

    // Reset mid-frame after 4 bits
    for (int i = 0; i < 4; i++) send_bit(fb[i]);
    chk("mid_cnt4", {5'd0, bus.cnt}, 8'h04);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_Q", bus.Q, 8'h00);
    chk("mid_rst_cnt", {5'd0, bus.cnt}, 8'h00);
    chk("mid_rst_busy", {7'd0, bus.busy}, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("mid_rst_done", {7'd0, bus.done}, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    chk("mid_after_done", {7'd0, bus.done}, 8'h00);
    chk("mid_after_cnt", {5'd0, bus.cnt}, 8'h01);
    chk("mid_after_Q", bus.Q, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
